wallace_multiplier_pipelined_param: RTL and testbench
=====================================================

// Module: wallace_multiplier_pipelined_param
// PURPOSE
//   Parametrised, pipelined Wallace-tree (3:2 CSA) multiplier with valid/ready flow control and
//   per-operation signed/unsigned mode. Generates WIDTH partial products, reduces them to two rows
//   through 3:2 carry-save levels with a register bank every LEVELS_PER_STAGE levels, then adds the
//   final sum/carry rows in a registered 2*WIDTH-bit adder. Successor to the fixed 32x32 multiplier,
//   used by the ALU/MAC datapath; a TAG travels with each operation.
// PARAMETERS
//   WIDTH             32  operand width; legal values 8,16,32,64 (others: $error at elaboration)
//   LEVELS_PER_STAGE   2  3:2 CSA levels between register banks; legal 1..4
//   TAG_W              4  width of sideband tag carried alongside each operation
// PORTS
//   clk        in   1         rising-edge clock
//   clear      in   1         synchronous active-high reset
//   in_valid   in   1         operand pair valid
//   in_ready   out  1         block can accept operands this cycle
//   in_signed  in   1         1: a,b two's complement; 0: unsigned
//   a          in   WIDTH     multiplicand
//   b          in   WIDTH     multiplier
//   in_tag     in   TAG_W     sideband tag, returned unchanged with the result
//   out_valid  out  1         product valid
//   out_ready  in   1         downstream accepts product this cycle
//   product    out  2*WIDTH   full-width product
//   out_tag    out  TAG_W     tag of the operation in product
// BEHAVIOUR
//   - Reduction depth D (3:2 levels from WIDTH rows to 2): WIDTH 8->4, 16->6, 32->8, 64->10.
//   - Register banks: after every LEVELS_PER_STAGE CSA levels (S = ceil(D/LEVELS_PER_STAGE) banks),
//     plus one bank on the final-adder output. LATENCY = S+1 cycles, input accept to out_valid;
//     e.g. WIDTH=32, LEVELS_PER_STAGE=2 -> LATENCY=5. Rows not consumed at a level are forwarded
//     (and registered) unchanged.
//   - Arithmetic: unsigned mode: product = a*b mod 2^(2W), exact. Signed mode: product = sext(a)*sext(b),
//     exact 2W-bit two's complement (Baugh-Wooley or sign-extended partial products; all carries
//     beyond bit 2W-1 discarded). Mode is captured per operation and pipelined with it.
//   - Each pipeline bank carries a valid bit, the tag and the mode with its data.
//   - Flow control: stall = out_valid & ~out_ready. When stall=1 every bank (incl. valid bits) holds.
//     in_ready = ~stall (combinational). Operation accepted when in_valid & in_ready.
//     With no stall, bubbles advance like data (no bubble compaction); throughput 1 op/cycle.
//   - product/out_tag remain stable while out_valid=1 and out_ready=0.
//   - in_valid=0 while in_ready=1: a bubble (valid=0) enters bank 0; datapath contents are don't-care
//     but product must read 0 whenever out_valid=0.
//   - clear=1: all valid bits, product, out_tag cleared to 0 on the next edge; in-flight ops are
//     discarded (no output ever appears for them). clear overrides stall. in_ready reads 1 from
//     the cycle after clear (out_valid=0).
//   - Reset values: out_valid=0, product=0, out_tag=0, in_ready=1.
//   - Simultaneous accept and output handshake in one cycle are both honoured.
// TESTING
//   1 Unsigned W=32: a=0xFFFFFFFF,b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 exactly LATENCY cycles later.
//   2 Signed W=32: a=0xFFFFFFFF(-1),b=0x00000003 -> 0xFFFFFFFFFFFFFFFD; a=0x80000000,b=0x80000000
//     -> 0x4000000000000000; same operands unsigned -> 0x4000000000000000 / 0x00000002FFFFFFFD for row1.
//   3 Back-to-back stream of 100 random ops (mixed modes, tags 0..15), out_ready=1 -> one result per
//     cycle, in order, tags matching, all products equal to reference model.
//   4 Backpressure: out_ready=0 for 7 cycles with out_valid=1 -> in_ready=0, product/out_tag frozen,
//     no op lost or duplicated after out_ready returns to 1.
//   5 clear asserted with 3 ops in flight and out_ready=0 -> next cycle out_valid=0, product=0,
//     in_ready=1; none of the 3 results ever appears.
//   6 Sweep WIDTH in {8,16,64} x LEVELS_PER_STAGE in {1,3}: W=8 a=0x80,b=0x7F signed -> 0xC080,
//     latency equals ceil(D/LEVELS_PER_STAGE)+1 per configuration.

Source files
------------

// File: rtl/wallace_multiplier_pipelined_param.sv
// Pipelined Wallace-tree multiplier: sign-aware partial products, 3:2 CSA levels with a register
// bank every LEVELS_PER_STAGE levels, then a registered final adder. Valid/tag ride with the data.
module wallace_multiplier_pipelined_param #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  function automatic int csa_depth(int rows);
    int r;
    int d;
    r = rows;
    d = 0;
    while (r > 2) begin
      r = r - r / 3;
      d++;
    end
    return d;
  endfunction

  localparam int W2 = 2 * WIDTH;
  localparam int D  = csa_depth(WIDTH);
  localparam int S  = (D + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int NG = WIDTH / 3;

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("wallace_multiplier_pipelined_param: WIDTH must be 8, 16, 32 or 64");
  end
  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > 4) begin : g_bad_lps
    $error("wallace_multiplier_pipelined_param: LEVELS_PER_STAGE must be 1..4");
  end

  logic [W2-1:0]    row_d [S][WIDTH];
  logic [W2-1:0]    row_q [S][WIDTH];
  logic [S-1:0]     vld_d, vld_q;
  logic [TAG_W-1:0] tag_d [S];
  logic [TAG_W-1:0] tag_q [S];
  logic             out_valid_d, out_valid_q;
  logic [W2-1:0]    prod_d, prod_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic             stall;

  // The signed/unsigned mode is folded into the partial-product rows at entry, so later banks
  // carry only rows, valid and tag.
  always_comb begin : reduce_tree
    logic [W2-1:0] cur [WIDTH];
    logic [W2-1:0] nxt [WIDTH];
    logic [W2-1:0] ext_a, x, y, z, maj;
    int n, g;

    stall = out_valid_q & ~out_ready;
    ext_a = in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    for (int i = 0; i < WIDTH; i++) cur[i] = b[i] ? (ext_a << i) : '0;
    // In signed mode the MSB of b weighs -2^(W-1), so its row is subtracted.
    if (in_signed && b[WIDTH-1]) cur[WIDTH-1] = '0 - (ext_a << (WIDTH-1));
    for (int i = 0; i < WIDTH; i++) nxt[i] = cur[i];
    x = '0;
    y = '0;
    z = '0;
    maj = '0;
    n = WIDTH;
    g = 0;
    for (int k = 0; k < S; k++)
      for (int i = 0; i < WIDTH; i++) row_d[k][i] = row_q[k][i];

    for (int l = 0; l < D; l++) begin
      if (l > 0 && l % LEVELS_PER_STAGE == 0)
        for (int i = 0; i < WIDTH; i++) cur[i] = row_q[l / LEVELS_PER_STAGE - 1][i];
      g = n / 3;
      for (int j = 0; j < WIDTH; j++) nxt[j] = '0;
      for (int j = 0; j < NG; j++) begin
        if (j < g) begin
          x = cur[3*j];
          y = cur[3*j+1];
          z = cur[3*j+2];
          maj = (x & y) | (x & z) | (y & z);
          nxt[2*j]   = x ^ y ^ z;
          nxt[2*j+1] = {maj[W2-2:0], 1'b0};
        end
      end
      for (int s = 0; s < WIDTH; s++)
        if (s >= 3 * g && s < n) nxt[s-g] = cur[s];
      n = n - g;
      if (!stall && ((l + 1) % LEVELS_PER_STAGE == 0 || l + 1 == D))
        for (int i = 0; i < WIDTH; i++) row_d[l / LEVELS_PER_STAGE][i] = nxt[i];
      for (int i = 0; i < WIDTH; i++) cur[i] = nxt[i];
    end

    vld_d = vld_q;
    for (int k = 0; k < S; k++) tag_d[k] = tag_q[k];
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    out_tag_d   = out_tag_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int k = 1; k < S; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      out_valid_d = vld_q[S-1];
      prod_d      = vld_q[S-1] ? row_q[S-1][0] + row_q[S-1][1] : '0;
      out_tag_d   = vld_q[S-1] ? tag_q[S-1] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      out_tag_q   <= '0;
      for (int k = 0; k < S; k++) tag_q[k] <= '0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      out_tag_q   <= out_tag_d;
      for (int k = 0; k < S; k++) tag_q[k] <= tag_d[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < S; k++)
      for (int i = 0; i < WIDTH; i++) row_q[k][i] <= row_d[k][i];
  end

  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign product   = prod_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_multiplier_pipelined_param.sv
// Scoreboard bench: driver pushes reference products on accept, negedge monitor pops and compares;
// generated side instances sweep WIDTH x LEVELS_PER_STAGE for latency and arithmetic.
module tb_wallace_multiplier_pipelined_param;
  localparam int W   = 32;
  localparam int LPS = 2;
  localparam int LAT = (8 + LPS - 1) / LPS + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b1, in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [W-1:0]  a = '0, b = '0;
  logic [3:0]    in_tag = '0, out_tag;
  logic [2*W-1:0] product;

  wallace_multiplier_pipelined_param #(.WIDTH(W), .LEVELS_PER_STAGE(LPS), .TAG_W(4)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .out_tag(out_tag));

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] p; logic [3:0] t; int acc; bit lat; } exp_t;
  exp_t sbq[$];

  task automatic check(string nm, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(bit s, logic [31:0] x, logic [31:0] y);
    if (s) return 64'(longint'($signed(x)) * longint'($signed(y)));
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic drive(bit v, bit s, logic [31:0] x, logic [31:0] y, logic [3:0] t, bit ordy,
                       bit clr, logic [63:0] e, bit lat);
    @(posedge clk); #1;
    in_valid = v; in_signed = s; a = x; b = y; in_tag = t; out_ready = ordy; clear = clr;
    #1;
    if (v && in_ready && !clr) sbq.push_back('{e, t, cyc, lat});
  endtask

  task automatic rnd_op(bit v, bit ordy);
    bit s;
    logic [31:0] x, y;
    logic [3:0] t;
    s = 1'($urandom_range(0, 1));
    x = $urandom;
    y = $urandom;
    if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
    t = 4'($urandom_range(0, 15));
    drive(v, s, x, y, t, ordy, 1'b0, ref_mul(s, x, y), 1'b0);
  endtask

  task automatic idle(bit ordy);
    drive(1'b0, 1'b0, '0, '0, '0, ordy, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) idle(1'b1);
    idle(1'b1);
    check("drain_empty", 128'(sbq.size()), 128'(0));
  endtask

  // Monitor
  logic [63:0] prev_p = '0;
  logic [3:0]  prev_t = '0;
  bit prev_stall = 1'b0, prev_clr = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (prev_stall && !prev_clr) begin
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_product", 128'(product), 128'(prev_p));
        check("hold_tag", 128'(out_tag), 128'(prev_t));
      end
      if (!out_valid) check("idle_product_zero", 128'(product), 128'(0));
      else if (out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_output: product 0x%0h tag %0d with nothing expected", product, out_tag);
        end else begin
          e = sbq.pop_front();
          check("product", 128'(product), 128'(e.p));
          check("tag", 128'(out_tag), 128'(e.t));
          if (e.lat) check("latency", 128'(cyc - e.acc), 128'(LAT));
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_p = product;
    prev_t = out_tag;
    prev_clr = clear;
  end

  // Configuration sweep instances
  localparam int SW[6] = '{8, 8, 16, 16, 64, 64};
  localparam int SL[6] = '{1, 3, 1, 3, 1, 3};
  for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
    localparam int GW   = SW[gi];
    localparam int GL   = SL[gi];
    localparam int GD   = (GW == 8) ? 4 : (GW == 16) ? 6 : (GW == 32) ? 8 : 10;
    localparam int GLAT = (GD + GL - 1) / GL + 1;
    logic s_clr = 1'b1, s_iv = 1'b0, s_sg = 1'b0, s_ir, s_ov;
    logic [GW-1:0] s_a = '0, s_b = '0;
    logic [3:0] s_it = '0, s_ot;
    logic [2*GW-1:0] s_p, e, ea, eb;
    bit done = 1'b0;

    wallace_multiplier_pipelined_param #(.WIDTH(GW), .LEVELS_PER_STAGE(GL), .TAG_W(4)) u_sw (
      .clk(clk), .clear(s_clr), .in_valid(s_iv), .in_ready(s_ir), .in_signed(s_sg),
      .a(s_a), .b(s_b), .in_tag(s_it), .out_valid(s_ov), .out_ready(1'b1),
      .product(s_p), .out_tag(s_ot));

    initial begin
      int lat;
      repeat (2) @(posedge clk);
      #1 s_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (k == 0 && GW == 8) begin
          s_sg = 1'b1; s_a = GW'(8'h80); s_b = GW'(8'h7F);
        end else begin
          s_sg = (k != 2);
          s_a = GW'({$urandom, $urandom});
          s_b = GW'({$urandom, $urandom});
        end
        s_it = 4'($urandom_range(0, 15));
        ea = s_sg ? {{GW{s_a[GW-1]}}, s_a} : {{GW{1'b0}}, s_a};
        eb = s_sg ? {{GW{s_b[GW-1]}}, s_b} : {{GW{1'b0}}, s_b};
        e = ea * eb;
        if (k == 0 && GW == 8) check("sweep_w8_c080", 128'(e), 128'(16'hC080));
        s_iv = 1'b1;
        @(posedge clk); #1;
        s_iv = 1'b0;
        lat = 1;
        while (!s_ov && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep_w%0d_l%0d_latency", GW, GL), 128'(lat), 128'(GLAT));
        check($sformatf("sweep_w%0d_l%0d_product", GW, GL), 128'(s_p), 128'(e));
        check($sformatf("sweep_w%0d_l%0d_tag", GW, GL), 128'(s_ot), 128'(s_it));
      end
      done = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
    idle(1'b1);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_product", 128'(product), 128'(0));
    check("reset_out_tag", 128'(out_tag), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1, 1'b1, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    repeat (LAT + 2) idle(1'b1);

    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3, 4'h2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h3, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 1'b1);
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h3, 4'h4, 1'b1, 1'b0, 64'h0000_0002_FFFF_FFFD, 1'b1);
    drive(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 4'h5, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 1'b1);
    drain();

    for (int k = 0; k < 100; k++) rnd_op(1'b1, 1'b1);
    repeat (LAT) idle(1'b1);
    @(negedge clk); #1;
    check("stream_throughput_empty", 128'(sbq.size()), 128'(0));

    cnt = 0;
    for (int k = 0; k < 13; k++) begin
      rnd_op(1'b1, 1'b0);
      if (out_valid) begin
        cnt++;
        check("stall_in_ready", 128'(in_ready), 128'(0));
      end
    end
    check("stall_cycles_ge7", 128'(cnt >= 7), 128'(1));
    for (int k = 0; k < 20; k++) rnd_op(1'b1, 1'b1);
    drain();

    for (int k = 0; k < 3; k++) rnd_op(1'b1, 1'b0);
    idle(1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
    idle(1'b1);
    sbq.delete();
    check("clear_out_valid", 128'(out_valid), 128'(0));
    check("clear_product", 128'(product), 128'(0));
    check("clear_in_ready", 128'(in_ready), 128'(1));
    repeat (12) idle(1'b1);

    for (int k = 0; k < 300; k++) rnd_op($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    drain();

    for (int k = 0; k < 3000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                                   g_sweep[3].done && g_sweep[4].done && g_sweep[5].done); k++)
      @(posedge clk);
    check("sweep_all_done", 128'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                                 g_sweep[3].done && g_sweep[4].done && g_sweep[5].done), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
